mem_access_unit: RTL
====================

# mem_access_unit

Multi-cycle data-memory access unit for the RV32 pipeline's MEM stage. It sits between the EX/MEM register and the data SRAM and replaces the single-cycle, aligned-only byte-select path. It adds:
- a request/ready handshake toward a variable-latency memory;
- a pipeline stall output;
- optional splitting of misaligned halfword/word accesses into two word beats;
- a registered, sign/zero-extended load response.

## Interface
Parameters:
- ADDR_W, 14, word-address width driven to the SRAM (byte address bits [ADDR_W+1:2]).
- SPLIT_EN, 1, 1 = misaligned accesses are split into two beats; 0 = misaligned accesses are rejected with acc_err.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage has a load/store this cycle.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data, right-aligned.
- dm_cs  out  1  memory beat request, held until dm_ready.
- dm_ready  in  1  beat completes in the cycle where dm_cs & dm_ready; load data is valid that cycle.
- dm_addr  out  ADDR_W  word address.
- dm_web  out  4  active-low per-byte write enable; 4'hF on reads.
- dm_di  out  32  lane-aligned write data.
- dm_rdata  in  32  read word.
- rsp_valid  out  1  one-cycle pulse, load result valid.
- rsp_data  out  32  extended load result, held until the next load.
- stall  out  1  freeze IF..MEM pipeline registers.
- acc_err  out  1  one-cycle pulse: illegal funct3, or misaligned access while SPLIT_EN=0.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE, ERR.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata and compute:
  - off = addr[1:0];
  - size = 1, 2 or 4 bytes;
  - split = off+size > 4.
- Illegal funct3 (load 3/6/7; store ≥3), or split with SPLIT_EN=0 → ERR. No memory access is made.
- Otherwise IDLE → BEAT0.
- BEAT0:
  - dm_cs=1, dm_addr=addr[ADDR_W+1:2].
  - dm_web low on lanes off..min(off+size,4)-1 for stores; 4'hF for loads.
  - dm_di = wdata rotated left by 8·off.
- BEAT0 + dm_ready:
  - Loads capture dm_rdata into lo_buf.
  - split → BEAT1, else → DONE.
- BEAT1:
  - dm_addr = beat0 address + 1, wrapping modulo 2^ADDR_W.
  - dm_web low on lanes 0..off+size-5; same rotated dm_di.
- BEAT1 + dm_ready: loads capture into hi_buf, → DONE.
- DONE:
  - Loads: rsp_valid=1; rsp_data = extend((lo_buf >> 8·off) | (hi_buf << 8·(4-off))).
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Stores: no response.
  - → IDLE.
- ERR: acc_err=1 for one cycle, → IDLE.
- stall = req_valid in IDLE, or state ∈ {BEAT0, BEAT1}. stall=0 in DONE and ERR so the pipeline advances exactly once per request.
- The requester holds req_* stable while stall=1. Inputs are sampled only at acceptance.
- Reset (any state, including mid-beat) → IDLE:
  - dm_cs=0, dm_web=4'hF, dm_addr=0, dm_di=0;
  - rsp_valid=0, rsp_data=0, acc_err=0, buffers cleared.
  - An in-flight beat is abandoned.

## Timing
- dm_* are registered outputs.
- Aligned access, dm_ready tied high: accept at T, beat at T+1, DONE/rsp_valid at T+2. Two stall cycles (T, T+1).
- Split access, dm_ready high: rsp_valid at T+3.
- Each dm_ready wait cycle adds one cycle.
- dm_cs/dm_addr/dm_web/dm_di stay constant while dm_cs=1 & !dm_ready.
- dm_ready while dm_cs=0 is ignored.
- A new request may be accepted in the cycle after DONE/ERR, i.e. one request per ≥3 cycles.

## Structure
- Package mem_access_pkg holds:
  - funct3 localparams (F3_LB..F3_SW);
  - state enum typedef;
  - functions size_of(funct3) and lane_mask(off, size).
- Sub-module mem_load_extend (combinational): merged word + funct3 → extended result.
- FSM, lane logic and buffers live in mem_access_unit.

## Test plan
- LW at 0x0000_0010, dm_rdata=0x8899AABB, dm_ready=1 → dm_addr=4, dm_web=4'hF; rsp_data=0x8899AABB at T+2; stall high for 2 cycles.
- SH 0x1234 at 0x0000_0006, dm_ready=1 → dm_addr=1, dm_web=4'b0011, dm_di[31:16]=0x1234; no rsp_valid.
- SW 0xDEADBEEF at 0x0000_0007, SPLIT_EN=1 → beat0 dm_addr=1, web=4'b0111, di[31:24]=0xEF; beat1 dm_addr=2, web=4'b1000, di[23:0]=0xDEADBE.
- LH at 0x0000_0003, SPLIT_EN=1: word0=0x80xxxxxx, word1=0xxxxxxxFF → rsp_data=0xFFFF_FF80. Repeat as LHU → 0x0000_FF80.
- LW at 0x0000_0002, SPLIT_EN=0 → acc_err pulse, dm_cs never asserted, no rsp_valid. LB with funct3=3 → acc_err.
- LW with dm_ready low for 5 cycles, rst pulsed low in cycle 3 → dm_cs=0, dm_web=4'hF, state IDLE, req_ready=1 immediately; no rsp_valid.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_pkg: funct3 codes, FSM states and lane helpers for the MEM-stage access unit
package mem_access_pkg;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, DONE, ERR} state_t;

  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    return funct3[1:0] == 2'd0 ? 3'd1 : funct3[1:0] == 2'd1 ? 3'd2 : 3'd4;
  endfunction

  // Bits [3:0] are the lanes of the first word, [7:4] the spill into the next word
  function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [2:0] size);
    return ((8'd1 << size) - 8'd1) << off;
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-wide data SRAM beat bus with chip-select/ready handshake
interface mem_access_unit_if #(parameter int ADDR_W = 14);
  logic              dm_cs;
  logic              dm_ready;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_web;
  logic [31:0]       dm_di;
  logic [31:0]       dm_rdata;
  modport master(output dm_cs, dm_addr, dm_web, dm_di, input dm_ready, dm_rdata);
  modport slave(input dm_cs, dm_addr, dm_web, dm_di, output dm_ready, dm_rdata);
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// mem_load_extend: picks byte/half/word from a merged load word and sign/zero-extends it
module mem_load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  always_comb
    result = funct3 == F3_LB  ? {{24{word[7]}}, word[7:0]} :
             funct3 == F3_LH  ? {{16{word[15]}}, word[15:0]} :
             funct3 == F3_LBU ? {24'd0, word[7:0]} :
             funct3 == F3_LHU ? {16'd0, word[15:0]} : word;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle MEM-stage load/store engine with misaligned split and stall
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  mem_access_unit_if.master   dm,
  output logic                rsp_valid,
  output logic [31:0]         rsp_data,
  output logic                stall,
  output logic                acc_err
);
  state_t      state;
  logic        we;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [7:0]  mask;
  logic        split;
  logic [31:0] lo_buf, hi_buf;
  logic [5:0]  in_sh;
  logic [7:0]  in_mask;
  logic        in_split, in_bad;
  logic [31:0] in_rot;
  logic [31:0] lo_src, hi_src, merged, ext;
  logic [5:0]  sh;

  assign in_sh    = {1'b0, req_addr[1:0], 3'b000};
  assign in_mask  = lane_mask(req_addr[1:0], size_of(req_funct3));
  assign in_split = |in_mask[7:4];
  assign in_bad   = req_we ? req_funct3 > 3'd2 : (req_funct3 == 3'd3 || req_funct3 > 3'd5);
  assign in_rot   = (req_wdata << in_sh) | (req_wdata >> (6'd32 - in_sh));

  // The word arriving this cycle is merged directly so the response registers on the final beat
  assign lo_src = state == BEAT0 ? dm.dm_rdata : lo_buf;
  assign hi_src = state == BEAT1 ? dm.dm_rdata : hi_buf;
  assign sh     = {1'b0, off, 3'b000};
  assign merged = (lo_src >> sh) | (hi_src << (6'd32 - sh));

  mem_load_extend u_ext (.word(merged), .funct3(f3), .result(ext));

  assign req_ready = state == IDLE;
  assign stall     = (state == IDLE && req_valid) || state == BEAT0 || state == BEAT1;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      we         <= 1'b0;
      f3         <= 3'd0;
      off        <= 2'd0;
      mask       <= 8'd0;
      split      <= 1'b0;
      lo_buf     <= 32'd0;
      hi_buf     <= 32'd0;
      dm.dm_cs   <= 1'b0;
      dm.dm_web  <= 4'hF;
      dm.dm_addr <= '0;
      dm.dm_di   <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 32'd0;
      acc_err    <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (req_valid) begin
            we    <= req_we;
            f3    <= req_funct3;
            off   <= req_addr[1:0];
            mask  <= in_mask;
            split <= in_split;
            if (in_bad || (in_split && !SPLIT_EN)) begin
              state   <= ERR;
              acc_err <= 1'b1;
            end else begin
              state      <= BEAT0;
              dm.dm_cs   <= 1'b1;
              dm.dm_addr <= req_addr[ADDR_W+1:2];
              dm.dm_web  <= req_we ? ~in_mask[3:0] : 4'hF;
              dm.dm_di   <= in_rot;
            end
          end
        BEAT0:
          if (dm.dm_ready) begin
            if (!we) lo_buf <= dm.dm_rdata;
            if (split) begin
              state      <= BEAT1;
              dm.dm_addr <= dm.dm_addr + ADDR_W'(1);
              dm.dm_web  <= we ? ~mask[7:4] : 4'hF;
            end else begin
              state     <= DONE;
              dm.dm_cs  <= 1'b0;
              dm.dm_web <= 4'hF;
              rsp_valid <= !we;
              if (!we) rsp_data <= ext;
            end
          end
        BEAT1:
          if (dm.dm_ready) begin
            if (!we) hi_buf <= dm.dm_rdata;
            state     <= DONE;
            dm.dm_cs  <= 1'b0;
            dm.dm_web <= 4'hF;
            rsp_valid <= !we;
            if (!we) rsp_data <= ext;
          end
        DONE: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
        ERR: begin
          state   <= IDLE;
          acc_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
